// File: rtl/imem_loader.sv
// ============================================================================
// imem_loader
// ----------------------------------------------------------------------------
// Boot-time instruction-memory loader. After a start pulse it reads a byte
// stream of the form
//     N (4 bytes, little-endian word count), then N words (4 bytes each, LE)
// and writes each assembled word into instruction memory at word address
// 0..N-1. The core is held in reset (cpu_rstn=0) until a load finishes
// successfully. A header count larger than the memory depth aborts the
// session in an error state without writing anything.
//
// Ports
//   clk          system clock, rising edge
//   rstn         asynchronous active-low reset
//   start        single-cycle pulse, begins a session from IDLE/DONE/ERR
//   byte_valid   source has a byte on byte_data this cycle
//   byte_data    stream byte
//   byte_ready   loader accepts a byte this cycle (HDR/DATA only)
//   imem_we      one-cycle word write strobe
//   imem_addr    word address of the write (0 when imem_we=0)
//   imem_wdata   word being written (0 when imem_we=0)
//   cpu_rstn     registered active-low reset to the core, high only in DONE
//   done         load completed successfully
//   err          header word count exceeded 2^DEPTH_LOG2
// ============================================================================
module imem_loader #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  imem_we,
    output logic [DEPTH_LOG2-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_rstn,
    output logic                  done,
    output logic                  err
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HDR   = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    // The word index carries one extra bit so that a full-depth load
    // (N = 2^DEPTH_LOG2) can count past the last address without wrapping
    // back to zero before the end-of-load comparison.
    localparam int         IDXW  = DEPTH_LOG2 + 1;
    localparam logic [32:0] DEPTH = 33'd1 << DEPTH_LOG2;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [2:0]      state_q,    state_d;
    logic [1:0]      bcnt_q,     bcnt_d;     // bytes accepted in current 4-byte group
    logic [31:0]     hdr_q,      hdr_d;      // header word count N
    logic [31:0]     word_q,     word_d;     // word under assembly
    logic [IDXW-1:0] idx_q,      idx_d;      // current word index
    logic            cpu_rstn_q;

    logic            accept;
    logic [31:0]     hdr_nxt;
    logic [31:0]     word_nxt;
    logic [32:0]     idx_inc;

    // Byte handshake: only the two byte-consuming states offer ready.
    assign byte_ready = (state_q == S_HDR) || (state_q == S_DATA);
    assign accept     = byte_ready && byte_valid;

    // Bytes arrive least-significant first, so shifting each new byte in at
    // the top leaves the first byte in bits 7:0 after four shifts.
    assign hdr_nxt  = {byte_data, hdr_q[31:8]};
    assign word_nxt = {byte_data, word_q[31:8]};

    // Index of the word being written plus one, widened for comparison
    // against the full 32-bit header count.
    assign idx_inc  = 33'(idx_q) + 33'd1;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        hdr_d   = hdr_q;
        word_d  = word_q;
        idx_d   = idx_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                // A new session starts from a clean slate.
                if (start) begin
                    state_d = S_HDR;
                    bcnt_d  = 2'd0;
                    hdr_d   = 32'd0;
                    word_d  = 32'd0;
                    idx_d   = '0;
                end
            end

            S_HDR: begin
                if (accept) begin
                    hdr_d  = hdr_nxt;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        // Decide on the fully assembled header, which
                        // includes the byte arriving this cycle.
                        if ({1'b0, hdr_nxt} > DEPTH) begin
                            state_d = S_ERR;
                        end else if (hdr_nxt == 32'd0) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end
            end

            S_DATA: begin
                if (accept) begin
                    word_d = word_nxt;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end

            S_WRITE: begin
                // The write happens this cycle using idx_q; the index
                // advances for the next word.
                idx_d = idx_inc[IDXW-1:0];
                if (idx_inc == {1'b0, hdr_q}) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DATA;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            bcnt_q     <= 2'd0;
            hdr_q      <= 32'd0;
            word_q     <= 32'd0;
            idx_q      <= '0;
            cpu_rstn_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bcnt_q     <= bcnt_d;
            hdr_q      <= hdr_d;
            word_q     <= word_d;
            idx_q      <= idx_d;
            // Registered from the next state so the core reset releases on
            // the same edge that enters DONE and drops on the edge that
            // leaves it, with no combinational path to the pin.
            cpu_rstn_q <= (state_d == S_DONE);
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign imem_we    = (state_q == S_WRITE);
    assign imem_addr  = imem_we ? idx_q[DEPTH_LOG2-1:0] : '0;
    assign imem_wdata = imem_we ? word_q : 32'd0;
    assign done       = (state_q == S_DONE);
    assign err        = (state_q == S_ERR);
    assign cpu_rstn   = cpu_rstn_q;

endmodule

// File: tb/tb_imem_loader.sv
// ============================================================================
// tb_imem_loader
// ----------------------------------------------------------------------------
// Directed and randomized sessions for imem_loader (DEPTH_LOG2 = 2, i.e. a
// 4-word memory). Expected writes come from a simple model: a session with
// header N <= 4 writes word i of the payload to address i for every i < N and
// ends in DONE; a larger N ends in ERR with no writes at all.
// ============================================================================
module tb_imem_loader;

    localparam int DL    = 2;
    localparam int DEPTH = 1 << DL;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = 8'd0;
    logic          byte_ready;
    logic          imem_we;
    logic [DL-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_rstn;
    logic          done;
    logic          err;

    imem_loader #(.DEPTH_LOG2(DL)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rstn   (cpu_rstn),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Write monitor, sampled on the falling edge
    // ------------------------------------------------------------------
    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];
    int          obs_cyc[$];

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            obs_addr.push_back(32'(imem_addr));
            obs_data.push_back(imem_wdata);
            obs_cyc.push_back(cyc);
            chk("ready_low_during_write", 64'(byte_ready), 64'd0);
        end else begin
            chk("bus_zero_when_idle", 64'({imem_addr, imem_wdata}), 64'd0);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    logic [31:0] wrd[4];
    int          last_acc_cyc = 0;
    int          acc4_cyc[$];
    int          end_cyc = 0;

    // Offer one byte until accepted; gap is the percent chance of an idle
    // (byte_valid=0, junk data) cycle.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit pulse_start);
        bit acc = 1'b0;
        int tries = 0;
        while (!acc && tries < 200) begin
            byte_valid = ($urandom_range(99) >= gap);
            byte_data  = byte_valid ? b : 8'($urandom);
            start      = pulse_start && (tries == 0);
            @(negedge clk);
            acc = byte_valid && byte_ready;
            @(posedge clk);
            #1;
            start = 1'b0;
            tries++;
        end
        byte_valid = 1'b0;
        byte_data  = 8'd0;
        if (acc) last_acc_cyc = cyc;
        else chk("byte_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_end();
        int t = 0;
        while (!(done || err) && t < 50) begin
            @(negedge clk);
            t++;
        end
        end_cyc = cyc;
        chk("session_end_reached", 64'(done | err), 64'd1);
    endtask

    task automatic clear_obs();
        obs_addr.delete();
        obs_data.delete();
        obs_cyc.delete();
        acc4_cyc.delete();
    endtask

    // One full session: start, header, payload (only if the header is legal),
    // then compare against the model.
    task automatic run_load(input logic [31:0] n, input int gap, input int pulse_at, input string tag);
        bit legal = (n <= 32'(DEPTH));
        int exp_n = legal ? int'(n) : 0;
        clear_obs();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, "_done_drop"},  64'(done),       64'd0);
        chk({tag, "_err_drop"},   64'(err),        64'd0);
        chk({tag, "_crst_drop"},  64'(cpu_rstn),   64'd0);
        chk({tag, "_hdr_ready"},  64'(byte_ready), 64'd1);
        for (int k = 0; k < 4; k++) send_byte(8'(n >> (8 * k)), gap, 1'b0);
        if (legal) begin
            for (int i = 0; i < exp_n; i++) begin
                for (int k = 0; k < 4; k++) begin
                    send_byte(8'(wrd[i] >> (8 * k)), gap, (4 + 4 * i + k) == pulse_at);
                end
                acc4_cyc.push_back(last_acc_cyc);
            end
        end
        wait_end();
        chk({tag, "_nwrites"}, 64'(obs_addr.size()), 64'(exp_n));
        for (int i = 0; i < exp_n && i < obs_addr.size(); i++) begin
            chk({tag, "_addr"},    64'(obs_addr[i]), 64'(i));
            chk({tag, "_data"},    64'(obs_data[i]), 64'(wrd[i]));
            chk({tag, "_latency"}, 64'(obs_cyc[i]),  64'(acc4_cyc[i]));
        end
        chk({tag, "_done"},     64'(done),     64'(legal));
        chk({tag, "_err"},      64'(err),      64'(!legal));
        chk({tag, "_cpu_rstn"}, 64'(cpu_rstn), 64'(legal));
    endtask

    task automatic rand_words();
        for (int i = 0; i < 4; i++) wrd[i] = $urandom;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"},    64'(byte_ready), 64'd0);
        chk({tag, "_we"},       64'(imem_we),    64'd0);
        chk({tag, "_addr"},     64'(imem_addr),  64'd0);
        chk({tag, "_wdata"},    64'(imem_wdata), 64'd0);
        chk({tag, "_cpu_rstn"}, 64'(cpu_rstn),   64'd0);
        chk({tag, "_done"},     64'(done),       64'd0);
        chk({tag, "_err"},      64'(err),        64'd0);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        #3 rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_needs_start", 64'(byte_ready), 64'd0);

        // Two-word load from the reference stream
        wrd[0] = 32'h0000_0013;
        wrd[1] = 32'h0000_006F;
        run_load(32'd2, 0, -1, "two_word");
        if (obs_cyc.size() >= 2) begin
            chk("throughput_5cyc",      64'(obs_cyc[1] - obs_cyc[0]), 64'd5);
            chk("done_after_last_write", 64'(end_cyc), 64'(obs_cyc[1] + 1));
        end

        // Empty load
        run_load(32'd0, 0, -1, "empty");

        // Oversized headers, then a full-depth load
        rand_words();
        run_load(32'd5, 0, -1, "over5");
        run_load(32'h0001_0002, 0, -1, "over_hi");
        run_load(32'd4, 0, -1, "full_depth");

        // Same three words with and without gaps
        rand_words();
        run_load(32'd3, 0, -1, "three_nogap");
        run_load(32'd3, 50, -1, "three_gap");

        // start pulsed during DATA is ignored
        rand_words();
        run_load(32'd2, 30, 6, "start_in_data");

        // Reset mid-session after 6 accepted bytes
        rand_words();
        clear_obs();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < 4; k++) send_byte(8'(32'd2 >> (8 * k)), 0, 1'b0);
        for (int k = 0; k < 2; k++) send_byte(8'(wrd[0] >> (8 * k)), 0, 1'b0);
        #2 rstn = 1'b0;
        #1;
        chk_all_zero("async_rst");
        repeat (3) @(posedge clk);
        #2 rstn = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'hA5;
        repeat (4) @(negedge clk);
        byte_valid = 1'b0;
        chk("rst_no_writes",     64'(obs_addr.size()), 64'd0);
        chk("rst_stays_idle",    64'(byte_ready),      64'd0);
        chk("rst_core_held",     64'(cpu_rstn),        64'd0);
        run_load(32'd2, 0, -1, "reload");

        // Randomized sessions
        for (int s = 0; s < 6; s++) begin
            rand_words();
            run_load(32'($urandom_range(5)), int'($urandom_range(60)), -1, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10, log2 of instruction-memory depth in 32-bit words.
REQ-002 SHALL have port clk  input  1  system clock, all state updates on rising edge.
REQ-003 SHALL have port rstn  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port start  input  1  single-cycle pulse that begins a load session.
REQ-005 SHALL have port byte_valid  input  1  source offers byte_data this cycle.
REQ-006 SHALL have port byte_data  input  8  incoming load-stream byte.
REQ-007 SHALL have port byte_ready  output  1  loader accepts a byte this cycle; transfer occurs when byte_valid and byte_ready are both high at a rising edge.
REQ-008 SHALL have port imem_we  output  1  instruction-memory word write strobe.
REQ-009 SHALL have port imem_addr  output  DEPTH_LOG2  word address of the write.
REQ-010 SHALL have port imem_wdata  output  32  word written.
REQ-011 SHALL have port cpu_rstn  output  1  active-low reset to the core; high only after a successful load.
REQ-012 SHALL have port done  output  1  load completed successfully.
REQ-013 SHALL have port err  output  1  header word count exceeded 2^DEPTH_LOG2.

Function
REQ-014 SHALL implement states IDLE, HDR, DATA, WRITE, DONE, ERR.
REQ-015 Stream format SHALL be: 4-byte header N (word count, little-endian), then N words of 4 bytes each, little-endian (first byte = bits 7:0).
REQ-016 IDLE: byte_ready=0; start -> HDR, clearing byte counter, word address, and header register.
REQ-017 HDR: byte_ready=1; after the 4th accepted byte, N>2^DEPTH_LOG2 -> ERR, N=0 -> DONE, otherwise -> DATA.
REQ-018 DATA: byte_ready=1; accepted bytes SHALL be assembled into a 32-bit shift register; after the 4th byte -> WRITE.
REQ-019 WRITE: byte_ready=0, imem_we=1 for exactly one cycle, imem_addr = current word index, imem_wdata = assembled word; next cycle the word index increments; index+1==N -> DONE, else -> DATA.
REQ-020 Byte-to-write latency SHALL be one cycle, from the edge accepting the 4th byte to the imem_we cycle; sustained throughput is one word per 5 cycles.
REQ-021 Cycles with byte_valid=0 in HDR/DATA SHALL stall without changing state or the partial word; byte_data SHALL be ignored when byte_valid=0.
REQ-022 DONE: done=1, cpu_rstn=1, byte_ready=0.
REQ-023 ERR: err=1, cpu_rstn=0, byte_ready=0; no imem_we SHALL ever be issued in a session ending in ERR.
REQ-024 start in DONE or ERR SHALL begin a new session (-> HDR) and drop done/err/cpu_rstn the following cycle.
REQ-025 start in HDR, DATA, or WRITE SHALL be ignored.
REQ-026 N=2^DEPTH_LOG2 SHALL be legal; the last write goes to address 2^DEPTH_LOG2-1, and the word index SHALL NOT wrap before DONE.
REQ-027 imem_addr and imem_wdata SHALL be 0 when imem_we=0.
REQ-028 cpu_rstn SHALL be a registered output, glitch-free.

Reset
REQ-029 rstn low SHALL immediately force state IDLE and byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_rstn=0, done=0, err=0, with all counters and registers cleared.
REQ-030 Reset asserted mid-session SHALL abandon the session, with no further imem_we; after rstn rises, a new start is required.

Verification
REQ-031 start; stream 02 00 00 00, 13 00 00 00, 6F 00 00 00 with byte_valid held high -> imem_we at addr 0 data 0x00000013, then at addr 1 data 0x0000006F; done=1 and cpu_rstn=1 one cycle after the second write.
REQ-032 start; header 00 00 00 00 -> DONE with zero imem_we pulses; cpu_rstn=1.
REQ-033 DEPTH_LOG2=2; header 05 00 00 00 -> err=1, cpu_rstn=0, no imem_we; a later start with header 04 00 00 00 and 16 bytes -> 4 writes to addr 0..3, then done=1.
REQ-034 Random byte_valid gaps (about 50% duty) during a 3-word load -> written words and addresses identical to the gap-free run; byte_ready=0 during each WRITE cycle.
REQ-035 rstn pulsed low after 6 accepted bytes of a 2-word load -> all outputs 0 asynchronously, no further writes; full reload after start succeeds.
REQ-036 start pulsed while in DATA -> ignored, load completes normally.
